vec_int_ctrl: RTL and testbench

- Parametrised, vectored interrupt controller for the processor; next generation of the 4-source hardwired-priority block.
- Supports 2**addrLen sources, per-source edge-latched pending bits and a maskable enable register.
- Vector table is writable at run time.
- Explicit request/acknowledge/done handshake with the control unit, driven by a 3-state FSM.

---
 rtl/vec_int_ctrl.sv | 159 +++++++++++++++
 tb/tb_vec_int_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, mask register,
// run-time writable vector table and a req/ack/done handshake FSM.
// Ports: clk, clr (async active-low reset), ints, intMask/ldMask,
//   intDisable, vecWrEn/vecWrAddr/vecWrData, intAck, intDone ->
//   isrAddr, activeId, intPending, inService
//   (+ nestDepth when INT_NEST_EN is defined).
// Optional macro INT_NEST_EN enables preemption by higher-priority sources.
module vec_int_ctrl #(
   parameter int pcWidth = 8,
   parameter int addrLen = 3
)(
   input  logic                    clk,
   input  logic                    clr,
   input  logic [2**addrLen-1:0]   ints,
   input  logic [2**addrLen-1:0]   intMask,
   input  logic                    ldMask,
   input  logic                    intDisable,
   input  logic                    vecWrEn,
   input  logic [addrLen-1:0]      vecWrAddr,
   input  logic [pcWidth-1:0]      vecWrData,
   input  logic                    intAck,
   input  logic                    intDone,
`ifdef INT_NEST_EN
   output logic [addrLen:0]        nestDepth,
`endif
   output logic [pcWidth-1:0]      isrAddr,
   output logic [addrLen-1:0]      activeId,
   output logic                    intPending,
   output logic                    inService
);

   localparam int nInts = 2**addrLen;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t               state, state_nxt;
   logic [nInts-1:0]     prev, pending, mask;
   logic [nInts-1:0]     edges, eligible, clr_bit;
   logic [pcWidth-1:0]   vec [nInts];
   logic [addrLen-1:0]   winner;
   logic                 any_elig;
   logic                 cap, take;

`ifdef INT_NEST_EN
   logic [addrLen:0]     depth, depth_m1;
   logic [addrLen-1:0]   stk_id   [nInts];
   logic [pcWidth-1:0]   stk_addr [nInts];
   logic                 push, pop;

   assign depth_m1  = depth - 1'b1;
   assign nestDepth = depth;
`endif

   assign edges    = ints & ~prev;
   assign eligible = pending & mask;
   assign any_elig = |eligible;

   // Lowest eligible index wins.
   always_comb begin
      winner = '0;
      for (int i = nInts-1; i >= 0; i--)
         if (eligible[i]) winner = addrLen'(i);
   end

   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      take      = 1'b0;
`ifdef INT_NEST_EN
      push      = 1'b0;
      pop       = 1'b0;
`endif
      unique case (state)
         IDLE:
            if (any_elig && !intDisable) begin
               cap       = 1'b1;
               state_nxt = REQ;
            end
         REQ:
            if (intAck && !intDisable) begin
               take      = 1'b1;
               state_nxt = SERVICE;
            end
         SERVICE: begin
`ifdef INT_NEST_EN
            // Return has priority over a same-cycle preemption.
            if (intDone) begin
               if (depth != '0) pop = 1'b1;
               else state_nxt = IDLE;
            end else if (any_elig && !intDisable
                         && winner < activeId) begin
               push      = 1'b1;
               cap       = 1'b1;
               state_nxt = REQ;
            end
`else
            if (intDone) state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign intPending = (state == REQ) && !intDisable;
   assign inService  = (state == SERVICE);

   // A new edge in the same cycle as the ack-clear keeps the bit set.
   assign clr_bit = take ? (nInts'(1) << activeId) : '0;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= IDLE;
         prev     <= '0;
         pending  <= '0;
         mask     <= '0;
         activeId <= '0;
         isrAddr  <= '0;
         for (int i = 0; i < nInts; i++)
            vec[i] <= pcWidth'(i * 4);
      end else begin
         state   <= state_nxt;
         prev    <= ints;
         pending <= (pending & ~clr_bit) | edges;
         if (ldMask)  mask <= intMask;
         if (vecWrEn) vec[vecWrAddr] <= vecWrData;
         if (cap) begin
            activeId <= winner;
            isrAddr  <= vec[winner];
         end
`ifdef INT_NEST_EN
         if (pop) begin
            activeId <= stk_id[depth_m1[addrLen-1:0]];
            isrAddr  <= stk_addr[depth_m1[addrLen-1:0]];
         end
`endif
      end
   end

`ifdef INT_NEST_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         depth <= '0;
      end else if (push) begin
         depth <= depth + 1'b1;
      end else if (pop) begin
         depth <= depth_m1;
      end
   end

   // Stack contents are only read below depth, so they need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stk_id[depth[addrLen-1:0]]   <= activeId;
         stk_addr[depth[addrLen-1:0]] <= isrAddr;
      end
   end
`endif

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Self-checking bench for vec_int_ctrl: table-driven offer-order vectors
// plus hand-written handshake, masking, conflict and reset sequences.
module tb_vec_int_ctrl;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] ints = '0;
   logic [7:0] intMask = '0;
   logic       ldMask = 1'b0;
   logic       intDisable = 1'b0;
   logic       vecWrEn = 1'b0;
   logic [2:0] vecWrAddr = '0;
   logic [7:0] vecWrData = '0;
   logic       intAck = 1'b0;
   logic       intDone = 1'b0;
   logic [7:0] isrAddr;
   logic [2:0] activeId;
   logic       intPending;
   logic       inService;
`ifdef INT_NEST_EN
   logic [3:0] nestDepth;
`endif

   vec_int_ctrl #(.pcWidth(8), .addrLen(3)) dut (
      .clk(clk), .clr(clr), .ints(ints),
      .intMask(intMask), .ldMask(ldMask),
      .intDisable(intDisable),
      .vecWrEn(vecWrEn), .vecWrAddr(vecWrAddr),
      .vecWrData(vecWrData),
      .intAck(intAck), .intDone(intDone),
`ifdef INT_NEST_EN
      .nestDepth(nestDepth),
`endif
      .isrAddr(isrAddr), .activeId(activeId),
      .intPending(intPending), .inService(inService)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [2:0] id;
      logic [7:0] addr;
   } exp_t;

   exp_t       sb [$];
   logic [7:0] tbvec [8];

   typedef struct packed {
      logic       wr;
      logic [2:0] wa;
      logic [7:0] wd;
      logic [7:0] mask;
      logic [7:0] pat;
      logic [7:0] expm;
   } tv_t;

   tv_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic do_reset();
      ints = '0; ldMask = 1'b0; intDisable = 1'b0;
      vecWrEn = 1'b0; intAck = 1'b0; intDone = 1'b0;
      clr = 1'b0;
      #1;
      chk("rst_isrAddr", 32'(isrAddr), 32'h0);
      chk("rst_activeId", 32'(activeId), 32'h0);
      chk("rst_intPending", 32'(intPending), 32'h0);
      chk("rst_inService", 32'(inService), 32'h0);
`ifdef INT_NEST_EN
      chk("rst_nestDepth", 32'(nestDepth), 32'h0);
`endif
      @(negedge clk);
      clr = 1'b1;
      for (int i = 0; i < 8; i++) tbvec[i] = 8'(i * 4);
      sb.delete();
   endtask

   task automatic load_mask(input logic [7:0] m);
      @(negedge clk);
      intMask = m; ldMask = 1'b1;
      @(negedge clk);
      ldMask = 1'b0;
   endtask

   task automatic wr_vec(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      vecWrAddr = a; vecWrData = d; vecWrEn = 1'b1;
      @(negedge clk);
      vecWrEn = 1'b0;
      tbvec[a] = d;
   endtask

   task automatic pulse(input logic [7:0] p);
      @(negedge clk);
      ints = p;
      @(negedge clk);
      ints = '0;
   endtask

   task automatic expect_id(input logic [2:0] id);
      sb.push_back('{id, tbvec[id]});
   endtask

   task automatic check_offer(input string nm);
      bit   ok;
      exp_t e;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (intPending) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({nm, "_offer_seen"}, 32'(ok), 32'h1);
      if (sb.size() == 0) begin
         chk({nm, "_sb_underflow"}, 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         chk({nm, "_activeId"}, 32'(activeId), 32'(e.id));
         chk({nm, "_isrAddr"}, 32'(isrAddr), 32'(e.addr));
      end
   endtask

   task automatic do_ack(input string nm);
      @(negedge clk);
      intAck = 1'b1;
      @(negedge clk);
      intAck = 1'b0;
      chk({nm, "_inService"}, 32'(inService), 32'h1);
      chk({nm, "_pend_low"}, 32'(intPending), 32'h0);
   endtask

   task automatic do_done();
      @(negedge clk);
      intDone = 1'b1;
      @(negedge clk);
      intDone = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h20, 8'h20};
      tbl[1] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h44, 8'h44};
      tbl[2] = '{1'b1, 3'd3, 8'hA0, 8'h08, 8'h08, 8'h08};
      tbl[3] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h81, 8'h81};
      tbl[4] = '{1'b0, 3'd0, 8'h00, 8'h0F, 8'hF0, 8'h00};
      tbl[5] = '{1'b1, 3'd7, 8'h55, 8'hFF, 8'hFF, 8'hFF};
      tbl[6] = '{1'b1, 3'd2, 8'h33, 8'hF0, 8'h3C, 8'h30};

      do_reset();

      // Two-edge latency from a single-cycle pulse on ints[5].
      load_mask(8'hFF);
      @(negedge clk);
      ints = 8'h20;
      @(negedge clk);
      ints = '0;
      chk("lat_edge_n", 32'(intPending), 32'h0);
      @(negedge clk);
      chk("lat_edge_n1", 32'(intPending), 32'h1);
      expect_id(3'd5);
      check_offer("lat");
      do_ack("lat");
      do_done();
      chk("lat_idle", 32'(inService), 32'h0);

      // Offer order for each table vector.
      for (int t = 0; t < 7; t++) begin
         do_reset();
         if (tbl[t].wr) wr_vec(tbl[t].wa, tbl[t].wd);
         load_mask(tbl[t].mask);
         pulse(tbl[t].pat);
         for (int i = 0; i < 8; i++)
            if (tbl[t].expm[i]) expect_id(3'(i));
         while (sb.size() != 0) begin
            check_offer($sformatf("tbl%0d", t));
            do_ack($sformatf("tbl%0d", t));
            do_done();
         end
         repeat (4) @(negedge clk);
         chk($sformatf("tbl%0d_quiet", t), 32'(intPending), 32'h0);
      end

      // Masked source held until its mask bit is loaded.
      do_reset();
      load_mask(8'h08);
      pulse(8'h02);
      repeat (5) @(negedge clk);
      chk("masked_no_offer", 32'(intPending), 32'h0);
      load_mask(8'h02);
      expect_id(3'd1);
      check_offer("unmask");
      do_ack("unmask");
      do_done();

      // Global disable blocks ack while in REQ.
      do_reset();
      load_mask(8'hFF);
      pulse(8'h08);
      expect_id(3'd3);
      check_offer("dis");
      intDisable = 1'b1;
      intAck = 1'b1;
      #1;
      chk("dis_comb_pend", 32'(intPending), 32'h0);
      @(negedge clk);
      chk("dis_hold_svc", 32'(inService), 32'h0);
      intAck = 1'b0;
      intDisable = 1'b0;
      #1;
      chk("dis_reoffer", 32'(intPending), 32'h1);
      do_ack("dis");
      do_done();

      // Mask change in REQ, ack/edge collision, reset mid-service.
      do_reset();
      load_mask(8'hFF);
      pulse(8'h10);
      expect_id(3'd4);
      check_offer("coll1");
      load_mask(8'h00);
      chk("mask_keeps_offer", 32'(intPending), 32'h1);
      load_mask(8'hFF);
      @(negedge clk);
      intAck = 1'b1;
      ints = 8'h10;
      @(negedge clk);
      intAck = 1'b0;
      ints = '0;
      chk("coll_svc", 32'(inService), 32'h1);
      do_done();
      expect_id(3'd4);
      check_offer("coll2");
      do_ack("coll2");
      do_reset();

`ifdef INT_NEST_EN
      do_reset();
      load_mask(8'hFF);
      pulse(8'h40);
      expect_id(3'd6);
      check_offer("nest_lo");
      do_ack("nest_lo");
      pulse(8'h02);
      expect_id(3'd1);
      check_offer("nest_hi");
      chk("nest_depth1", 32'(nestDepth), 32'h1);
      do_ack("nest_hi");
      do_done();
      chk("nest_ret_id", 32'(activeId), 32'h6);
      chk("nest_ret_addr", 32'(isrAddr), 32'(tbvec[6]));
      chk("nest_ret_svc", 32'(inService), 32'h1);
      chk("nest_depth0", 32'(nestDepth), 32'h0);
      do_done();
      chk("nest_idle", 32'(inService), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
